// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronised release of NUM_DOMAINS active-low resets, software reset and cause reporting.
// Define RSTSEQ_WATCHDOG_EN to build the watchdog that forces a reset when it is not kicked in time.
module reset_sequencer #(
  parameter int NUM_DOMAINS  = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STAGE_DELAY  = 16,
  parameter int SWRST_CYCLES = 8,
  parameter int WDT_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   swrst_req_i,
  input  logic                   wdt_kick_i,
  input  logic [WDT_WIDTH-1:0]   wdt_load_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_no,
  output logic                   seq_busy_o,
  output logic                   seq_done_o,
  output logic                   wdt_expired_o,
  output logic [1:0]             rst_cause_o
);

  localparam int MAX_CNT = (STAGE_DELAY > SWRST_CYCLES) ? STAGE_DELAY : SWRST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SWRST_CYCLES - 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_DONE, ST_SWRST} state_e;
  typedef enum logic [1:0] {CAUSE_EXT = 2'b00, CAUSE_SW = 2'b01, CAUSE_WDT = 2'b10} cause_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_synced;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d, dom_step;
  cause_e                 cause_q, cause_d;
  logic                   advance;
  logic                   wdt_fire;

  assign rst_synced = sync_q[SYNC_STAGES-1];
  assign dom_step   = (dom_q << 1) | NUM_DOMAINS'(1);

  // The edge that leaves ASSERT already counts as the first delay edge, so domain k
  // releases SYNC_STAGES + (k+1)*STAGE_DELAY edges after reset_i rises.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    cause_d = cause_q;
    advance = 1'b0;
    unique case (state_q)
      ST_ASSERT: begin
        if (rst_synced) begin
          state_d = ST_RELEASE;
          advance = 1'b1;
        end
      end
      ST_RELEASE: advance = 1'b1;
      ST_DONE: begin
        if (wdt_fire) begin
          state_d = ST_SWRST;
          cnt_d   = '0;
          dom_d   = '0;
          cause_d = CAUSE_WDT;
        end else if (swrst_req_i) begin
          state_d = ST_SWRST;
          cnt_d   = '0;
          dom_d   = '0;
          cause_d = CAUSE_SW;
        end
      end
      ST_SWRST: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (advance) begin
      if (cnt_q == STAGE_LAST) begin
        cnt_d = '0;
        dom_d = dom_step;
        if (&dom_step) state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q  <= '0;
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      dom_q   <= '0;
      cause_q <= CAUSE_EXT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      cause_q <= cause_d;
    end
  end

`ifdef RSTSEQ_WATCHDOG_EN
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
  logic                 wdt_exp_q;

  // A kick on the expiry edge reloads instead of firing; a zero load never reaches 1.
  assign wdt_fire = (state_q == ST_DONE) && !wdt_kick_i && (wdt_q == WDT_WIDTH'(1));

  always_comb begin
    wdt_d = wdt_q;
    if (state_q != ST_DONE) begin
      if (state_d == ST_DONE) wdt_d = wdt_load_i;
    end else if (wdt_kick_i) begin
      wdt_d = wdt_load_i;
    end else if (wdt_q != '0) begin
      wdt_d = wdt_q - WDT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wdt_q     <= '0;
      wdt_exp_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      wdt_exp_q <= wdt_fire;
    end
  end

  assign wdt_expired_o = wdt_exp_q;
`else
  logic unused_wdt;
  assign unused_wdt    = ^{wdt_kick_i, wdt_load_i};
  assign wdt_fire      = 1'b0;
  assign wdt_expired_o = 1'b0;
`endif

  assign domain_rst_no = dom_q;
  assign seq_done_o    = (state_q == ST_DONE);
  assign seq_busy_o    = ~seq_done_o;
  assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random traffic against a timeline model.
// Watchdog scenarios run only when RSTSEQ_WATCHDOG_EN is defined.
module tb_reset_sequencer;

  localparam int NUM_DOMAINS  = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int STAGE_DELAY  = 16;
  localparam int SWRST_CYCLES = 8;
  localparam int WDT_WIDTH    = 16;
`ifdef RSTSEQ_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic                   swrst_req_i;
  logic                   wdt_kick_i;
  logic [WDT_WIDTH-1:0]   wdt_load_i;
  logic [NUM_DOMAINS-1:0] domain_rst_no;
  logic                   seq_busy_o;
  logic                   seq_done_o;
  logic                   wdt_expired_o;
  logic [1:0]             rst_cause_o;

  reset_sequencer #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .SYNC_STAGES (SYNC_STAGES),
    .STAGE_DELAY (STAGE_DELAY),
    .SWRST_CYCLES(SWRST_CYCLES),
    .WDT_WIDTH   (WDT_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .swrst_req_i  (swrst_req_i),
    .wdt_kick_i   (wdt_kick_i),
    .wdt_load_i   (wdt_load_i),
    .domain_rst_no(domain_rst_no),
    .seq_busy_o   (seq_busy_o),
    .seq_done_o   (seq_done_o),
    .wdt_expired_o(wdt_expired_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model: m_n counts edges since reset_i rose; domains release every STAGE_DELAY
  // edges measured from m_origin; the watchdog fires m_load_val edges after its last load.
  int m_n, m_origin, m_cause, m_load_edge, m_load_val;
  bit m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rel_at(input int t);
    int r;
    if (t < m_origin) return 0;
    r = (t - m_origin) / STAGE_DELAY;
    return (r > NUM_DOMAINS) ? NUM_DOMAINS : r;
  endfunction

  function automatic bit model_done();
    return rel_at(m_n) == NUM_DOMAINS;
  endfunction

  task automatic model_reset();
    m_n         = 0;
    m_origin    = SYNC_STAGES;
    m_cause     = 0;
    m_exp       = 1'b0;
    m_load_edge = 0;
    m_load_val  = 0;
  endtask

  task automatic model_edge();
    bit was_done, fire;
    m_n++;
    was_done = (rel_at(m_n - 1) == NUM_DOMAINS);
    m_exp    = 1'b0;
    if (was_done) begin
      fire = WDT_ON && !wdt_kick_i && (m_load_val != 0) && (m_n == m_load_edge + m_load_val);
      if (fire) begin
        m_origin = m_n + SWRST_CYCLES;
        m_cause  = 2;
        m_exp    = 1'b1;
      end else if (swrst_req_i) begin
        m_origin = m_n + SWRST_CYCLES;
        m_cause  = 1;
      end else if (wdt_kick_i) begin
        m_load_edge = m_n;
        m_load_val  = int'(wdt_load_i);
      end
    end else if (rel_at(m_n) == NUM_DOMAINS) begin
      m_load_edge = m_n;
      m_load_val  = int'(wdt_load_i);
    end
  endtask

  task automatic check_outputs(input string tag);
    int r;
    logic [NUM_DOMAINS-1:0] m;
    r = rel_at(m_n);
    m = '0;
    for (int i = 0; i < r; i++) m[i] = 1'b1;
    check({tag, "_dom"},   32'(domain_rst_no), 32'(m));
    check({tag, "_done"},  32'(seq_done_o),    32'(r == NUM_DOMAINS));
    check({tag, "_busy"},  32'(seq_busy_o),    32'(r != NUM_DOMAINS));
    check({tag, "_exp"},   32'(wdt_expired_o), 32'(m_exp));
    check({tag, "_cause"}, 32'(rst_cause_o),   32'(m_cause));
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (reset_i) model_edge();
    @(negedge clk_i);
    check_outputs("cyc");
  endtask

  // Called on a falling clock edge: reset_i drops mid-cycle and outputs must follow without a clock.
  task automatic drop_reset(input string tag);
    #1 reset_i = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    check({tag, "_async_dom"}, 32'(domain_rst_no), 32'h0);
  endtask

  task automatic power_on_run(input string tag);
    for (int i = 0; i < 70; i++) begin
      tick();
      case (m_n)
        17: check({tag, "_e17"}, 32'(domain_rst_no), 32'h0);
        18: check({tag, "_e18"}, 32'(domain_rst_no), 32'h1);
        34: check({tag, "_e34"}, 32'(domain_rst_no), 32'h3);
        50: check({tag, "_e50"}, 32'(domain_rst_no), 32'h7);
        65: check({tag, "_e65_done"}, 32'(seq_done_o), 32'h0);
        66: begin
          check({tag, "_e66"}, 32'(domain_rst_no), 32'hf);
          check({tag, "_e66_done"}, 32'(seq_done_o), 32'h1);
          check({tag, "_e66_cause"}, 32'(rst_cause_o), 32'h0);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int e0, pulses, pedge;
    reset_i     = 1'b1;
    swrst_req_i = 1'b0;
    wdt_kick_i  = 1'b0;
    wdt_load_i  = '0;

    // Power-on
    #2 reset_i = 1'b0;
    model_reset();
    #1 check_outputs("por_async");
    repeat (3) tick();
    reset_i = 1'b1;
    power_on_run("por");

    // Software reset, with extra requests during hold and release that must be ignored
    repeat ($urandom_range(1, 10)) tick();
    swrst_req_i = 1'b1;
    tick();
    swrst_req_i = 1'b0;
    e0 = m_n;
    check("sw_dom", 32'(domain_rst_no), 32'h0);
    check("sw_cause", 32'(rst_cause_o), 32'h1);
    check("sw_busy", 32'(seq_busy_o), 32'h1);
    for (int i = 0; i < 80; i++) begin
      swrst_req_i = (m_n == e0 + 4) || (m_n == e0 + 12);
      tick();
      if (m_n == e0 + 8)  check("sw_hold", 32'(domain_rst_no), 32'h0);
      if (m_n == e0 + 23) check("sw_pre_rel", 32'(domain_rst_no), 32'h0);
      if (m_n == e0 + 24) check("sw_rel0", 32'(domain_rst_no), 32'h1);
      if (m_n == e0 + 72) check("sw_done", 32'(seq_done_o), 32'h1);
    end
    swrst_req_i = 1'b0;

    // Reset dropped between edges 40 and 41
    drop_reset("mid_pre");
    repeat (3) tick();
    reset_i = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("mid_e40", 32'(domain_rst_no), 32'h3);
    drop_reset("mid");
    repeat (2) tick();
    reset_i = 1'b1;
    power_on_run("mid_rerun");

    // Glitch after a software reset: cause must return to external
    swrst_req_i = 1'b1;
    tick();
    swrst_req_i = 1'b0;
    check("gl_sw_cause", 32'(rst_cause_o), 32'h1);
    repeat (80) tick();
    #1 reset_i = 1'b0;
    model_reset();
    #1 check_outputs("glitch");
    check("glitch_cause", 32'(rst_cause_o), 32'h0);
    check("glitch_busy", 32'(seq_busy_o), 32'h1);
    #1 reset_i = 1'b1;
    power_on_run("glitch_rerun");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      swrst_req_i = ($urandom_range(0, 39) == 0);
      wdt_kick_i  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) wdt_load_i = WDT_WIDTH'($urandom_range(0, 40));
      tick();
    end
    swrst_req_i = 1'b0;
    wdt_kick_i  = 1'b0;

`ifdef RSTSEQ_WATCHDOG_EN
    // Unkicked watchdog with load 10 expires 10 edges after DONE entry at edge 66
    drop_reset("wdt_por");
    wdt_load_i = WDT_WIDTH'(10);
    repeat (3) tick();
    reset_i = 1'b1;
    pulses = 0;
    pedge  = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wdt_expired_o) begin
        pulses++;
        pedge = m_n;
      end
      if (m_n == 76) begin
        check("wdt_cause", 32'(rst_cause_o), 32'h2);
        check("wdt_dom", 32'(domain_rst_no), 32'h0);
      end
    end
    check("wdt_pulse_count", 32'(pulses), 32'h1);
    check("wdt_pulse_edge", 32'(pedge), 32'd76);

    for (int i = 0; i < 200 && !model_done(); i++) tick();
    check("wdt_redone", 32'(seq_done_o), 32'h1);

    // Kicked every 5 cycles: never expires
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      wdt_kick_i = (i % 5 == 0);
      tick();
      pulses += int'(wdt_expired_o);
    end
    wdt_kick_i = 1'b0;
    check("wdt_kick_pulses", 32'(pulses), 32'h0);
    check("wdt_kick_done", 32'(seq_done_o), 32'h1);

    // Zero load disables expiry
    wdt_load_i = '0;
    wdt_kick_i = 1'b1;
    tick();
    wdt_kick_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      pulses += int'(wdt_expired_o);
    end
    check("wdt_off_pulses", 32'(pulses), 32'h0);
    check("wdt_off_done", 32'(seq_done_o), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
